// File: rtl/muldiv_unit.sv
// Iterative signed 32x32 multiply (Booth) / divide (restoring) producing a 64-bit Rc.
// Define MULDIV_RADIX4_EN for a 16-iteration radix-4 Booth multiply; the divide is unaffected.
module muldiv_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] Ra,
  input  logic [31:0] Rb,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [63:0] Rc
);

  localparam logic [4:0] OP_MUL = 5'b01101;
  localparam logic [4:0] OP_DIV = 5'b01100;
`ifdef MULDIV_RADIX4_EN
  localparam logic [5:0] MUL_LAST = 6'd15;
`else
  localparam logic [5:0] MUL_LAST = 6'd31;
`endif
  localparam logic [5:0] DIV_LAST = 6'd31;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [33:0] acc;     // Booth accumulator, or partial remainder in acc[31:0]
  logic [31:0] q;       // multiplier / dividend magnitude, becomes product low / quotient
  logic [31:0] m;       // multiplicand, or divisor magnitude
  logic        qm1;
  logic        is_div, neg_a, neg_q;

  logic [33:0] m_ext, booth_sum, acc_mul;
  logic [31:0] q_mul;
  logic        qm1_mul;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_fix, rem_fix, dividend;

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (start) begin
        if (opcode == OP_MUL)      state_nxt = S_MUL;
        else if (opcode == OP_DIV) state_nxt = S_DIV;
      end
      S_MUL:  if (cnt == MUL_LAST) state_nxt = S_FIX;
      S_DIV:  if (m == 32'd0) state_nxt = S_DONE;
              else if (cnt == DIV_LAST) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_ext     = {{2{m[31]}}, m};
    booth_sum = acc;
`ifdef MULDIV_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: booth_sum = acc + m_ext;
      3'b011:         booth_sum = acc + {m_ext[32:0], 1'b0};
      3'b100:         booth_sum = acc - {m_ext[32:0], 1'b0};
      3'b101, 3'b110: booth_sum = acc - m_ext;
      default:        booth_sum = acc;
    endcase
    acc_mul = {{2{booth_sum[33]}}, booth_sum[33:2]};
    q_mul   = {booth_sum[1:0], q[31:2]};
    qm1_mul = q[1];
`else
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    acc_mul = {booth_sum[33], booth_sum[33:1]};
    q_mul   = {booth_sum[0], q[31:1]};
    qm1_mul = q[0];
`endif
  end

  always_comb begin
    rem_sh   = {acc[31:0], q[31]};
    diff     = rem_sh - {1'b0, m};
    quo_fix  = neg_q ? (~q + 32'd1) : q;
    rem_fix  = neg_a ? (~acc[31:0] + 32'd1) : acc[31:0];
    // q still holds |Ra| on the first divide edge, so the dividend is rebuilt from it
    dividend = neg_a ? (~q + 32'd1) : q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= S_IDLE;
      cnt         <= 6'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Rc          <= 64'd0;
      acc         <= 34'd0;
      q           <= 32'd0;
      m           <= 32'd0;
      qm1         <= 1'b0;
      is_div      <= 1'b0;
      neg_a       <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: if (start && (opcode == OP_MUL || opcode == OP_DIV)) begin
          cnt         <= 6'd0;
          div_by_zero <= 1'b0;
          acc         <= 34'd0;
          qm1         <= 1'b0;
          is_div      <= (opcode == OP_DIV);
          neg_a       <= Ra[31];
          neg_q       <= Ra[31] ^ Rb[31];
          if (opcode == OP_MUL) begin
            q <= Rb;
            m <= Ra;
          end else begin
            q <= Ra[31] ? (~Ra + 32'd1) : Ra;
            m <= Rb[31] ? (~Rb + 32'd1) : Rb;
          end
        end
        S_MUL: begin
          acc <= acc_mul;
          q   <= q_mul;
          qm1 <= qm1_mul;
          cnt <= cnt + 6'd1;
        end
        S_DIV: begin
          if (m == 32'd0) begin
            Rc          <= {dividend, 32'hFFFF_FFFF};
            div_by_zero <= 1'b1;
          end else begin
            if (!diff[32]) begin
              acc <= {1'b0, diff};
              q   <= {q[30:0], 1'b1};
            end else begin
              acc <= {1'b0, rem_sh};
              q   <= {q[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end
        end
        S_FIX: begin
          if (is_div) Rc <= {rem_fix, quo_fix};
          else        Rc <= {acc[31:0], q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus multi-cycle corner sequences.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MUL = 5'b01101;
  localparam logic [4:0] OP_DIV = 5'b01100;
  localparam logic [4:0] OP_ADD = 5'b00001;
`ifdef MULDIV_RADIX4_EN
  localparam int MUL_LAT = 18;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [4:0]  opcode;
  logic [31:0] Ra, Rb;
  logic        busy, done, div_by_zero;
  logic [63:0] Rc;

  muldiv_unit dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .Ra(Ra), .Rb(Rb), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .Rc(Rc)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge; start is sampled on the next posedge (E0).
  // lat = n where done is seen in the cycle after E_n; -1 on timeout.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy_ok);
    opcode = op; Ra = a; Rb = b; start = 1'b1;
    lat = -1; busy_ok = 1'b1;
    @(posedge clock);
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (n == 0) begin
        start = 1'b0; Ra = 32'hDEAD_BEEF; Rb = 32'h1234_5678; opcode = 5'b00000;
      end
      if (done) begin
        if (busy) busy_ok = 1'b0;
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] rc;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat;
    logic        bok;
    logic        seen;

    vecs[0]  = '{OP_MUL, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, MUL_LAT};
    vecs[1]  = '{OP_DIV, 32'hFFFF_FFEF, 32'd5,         64'hFFFF_FFFE_FFFF_FFFD, 1'b0, DIV_LAT};
    vecs[2]  = '{OP_DIV, 32'd9,          32'd0,         64'h0000_0009_FFFF_FFFF, 1'b1, 2};
    vecs[3]  = '{OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, MUL_LAT};
    vecs[4]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, MUL_LAT};
    vecs[5]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, DIV_LAT};
    vecs[6]  = '{OP_DIV, 32'd100,        32'd7,         64'h0000_0002_0000_000E, 1'b0, DIV_LAT};
    vecs[7]  = '{OP_DIV, 32'd7,          32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, DIV_LAT};
    vecs[8]  = '{OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 1'b0, DIV_LAT};
    vecs[9]  = '{OP_DIV, 32'd3,          32'd10,        64'h0000_0003_0000_0000, 1'b0, DIV_LAT};
    vecs[10] = '{OP_MUL, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, 1'b0, MUL_LAT};
    vecs[11] = '{OP_DIV, 32'h8000_0000, 32'd0,         64'h8000_0000_FFFF_FFFF, 1'b1, 2};

    clear = 1'b1; start = 1'b0; opcode = 5'b00000; Ra = 32'd0; Rb = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check64("reset_busy", {63'd0, busy}, 64'd0);
    check64("reset_done", {63'd0, done}, 64'd0);
    check64("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
    check64("reset_rc",   Rc, 64'd0);
    clear = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      check64($sformatf("vec%0d_rc", i), Rc, vecs[i].rc);
      check64($sformatf("vec%0d_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dbz});
      check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check64($sformatf("vec%0d_busy", i), {63'd0, bok}, 64'd1);
    end

    // Start while busy is ignored; also clears the flag left by the last divide-by-zero.
    opcode = OP_MUL; Ra = 32'h8000_0000; Rb = 32'h8000_0000; start = 1'b1;
    lat = -1;
    @(posedge clock);
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (n == 0) start = 1'b0;
      if (n == 9) begin start = 1'b1; opcode = OP_DIV; Ra = 32'd5; Rb = 32'd0; end
      if (n == 10) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    check64("busy_start_rc", Rc, 64'h4000_0000_0000_0000);
    check_int("busy_start_latency", lat, MUL_LAT);
    check64("busy_start_dbz", {63'd0, div_by_zero}, 64'd0);

    // Clear at E15 of a divide aborts it.
    opcode = OP_DIV; Ra = 32'd100; Rb = 32'd7; start = 1'b1;
    @(posedge clock);
    seen = 1'b0;
    for (int n = 0; n <= 14; n++) begin
      @(negedge clock);
      if (n == 0) start = 1'b0;
      if (done) seen = 1'b1;
      if (n == 14) clear = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    check64("clear_busy", {63'd0, busy}, 64'd0);
    check64("clear_rc", Rc, 64'd0);
    check64("clear_dbz", {63'd0, div_by_zero}, 64'd0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    check64("clear_no_done", {63'd0, seen}, 64'd0);
    do_op(OP_MUL, 32'd3, 32'd4, lat, bok);
    check64("after_clear_rc", Rc, 64'd12);
    check_int("after_clear_latency", lat, MUL_LAT);

    // Back-to-back: the second start lands in the done cycle of the first.
    do_op(OP_MUL, 32'd2, 32'd3, lat, bok);
    check64("b2b_first_rc", Rc, 64'd6);
    do_op(OP_MUL, 32'hFFFF_FFFB, 32'd6, lat, bok);
    check64("b2b_second_rc", Rc, 64'hFFFF_FFFF_FFFF_FFE2);
    check_int("b2b_second_latency", lat, MUL_LAT);
    check64("b2b_second_busy", {63'd0, bok}, 64'd1);

    // Unsupported opcode: no busy, no done, Rc untouched.
    opcode = OP_ADD; Ra = 32'd1; Rb = 32'd1; start = 1'b1;
    @(posedge clock);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy || done) seen = 1'b1;
    end
    check64("add_quiet", {63'd0, seen}, 64'd0);
    check64("add_rc_hold", Rc, 64'hFFFF_FFFF_FFFF_FFE2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
